reaction_round_ctrl: RTL and testbench

REACTION_ROUND_CTRL -- requirements
Module: reaction_round_ctrl

---
 rtl/reaction_pkg.sv | 27 ++
 rtl/press_edge_detect.sv | 27 ++
 rtl/reaction_round_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_reaction_round_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared states, display-select codes and lamp indices for the reaction game
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_DELAY,
        ST_GO,
        ST_RESULT,
        ST_OVER
    } state_e;

    localparam logic [1:0] SEL_TIME  = 2'd0;
    localparam logic [1:0] SEL_SCORE = 2'd1;
    localparam logic [1:0] SEL_WIN   = 2'd2;
    localparam logic [1:0] SEL_BLANK = 2'd3;

    localparam int LED_P1    = 9;
    localparam int LED_P2    = 8;
    localparam int LED_TIE   = 7;
    localparam int LED_FALSE = 6;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/press_edge_detect.sv
// rtl/press_edge_detect.sv - 1-bit rising-edge detector with registered history
module press_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic edge_out
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig_in;
    end

    // History resets to "held" so a button pressed through reset must be released first.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign edge_out = sig_in & ~prev_q;

endmodule

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - reaction-game round sequencer; FALSE_START_DETECT_EN enables early-press penalties
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int WIN_SCORE  = 5,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        resume,
    input  logic        p1,
    input  logic        p2,
    input  logic [19:0] counter,
    input  logic        rnd_ready,
    input  logic [13:0] rnd_num,
    output logic        counter_pause,
    output logic        counter_reset,
    output logic        rng_resume,
    output logic [1:0]  MUL_sel,
    output logic [19:0] output_num,
    output logic [9:0]  LEDs
);

    localparam logic [3:0]  WIN_Q     = 4'(WIN_SCORE);
    localparam logic [19:0] TIMEOUT_Q = 20'(TIMEOUT_MS);

    logic p1_e, p2_e, res_e, early_e;
    logic p1_pt, p2_pt;

    state_e      state_q, state_d;
    logic [3:0]  p1_score_q, p1_score_d;
    logic [3:0]  p2_score_q, p2_score_d;
    logic [13:0] delay_q, delay_d;
    logic [19:0] num_q, num_d;
    logic [9:0]  leds_q, leds_d;
    logic [1:0]  sel_q, sel_d;
    logic        pause_q, pause_d;
    logic        creset_q, creset_d;
    logic        rngr_q, rngr_d;

    press_edge_detect u_p1_edge  (.clock(clock), .reset(reset), .sig_in(p1),     .edge_out(p1_e));
    press_edge_detect u_p2_edge  (.clock(clock), .reset(reset), .sig_in(p2),     .edge_out(p2_e));
    press_edge_detect u_res_edge (.clock(clock), .reset(reset), .sig_in(resume), .edge_out(res_e));

`ifdef FALSE_START_DETECT_EN
    assign early_e = p1_e | p2_e;
`else
    assign early_e = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        delay_d    = delay_q;
        num_d      = num_q;
        leds_d     = leds_q;
        sel_d      = sel_q;
        pause_d    = pause_q;
        creset_d   = 1'b0;
        rngr_d     = 1'b0;
        p1_pt      = 1'b0;
        p2_pt      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (res_e) begin
                    state_d = ST_ARM;
                    rngr_d  = 1'b1;
                end
            end
            ST_ARM: begin
                if (rnd_ready) begin
                    delay_d  = rnd_num;
                    creset_d = 1'b1;
                    state_d  = ST_DELAY;
                end
            end
            ST_DELAY: begin
                // The counter still shows the old round while its clear pulse is in flight.
                if (early_e) begin
                    p1_pt             = p2_e & ~p1_e;
                    p2_pt             = p1_e & ~p2_e;
                    num_d             = 20'd0;
                    leds_d            = 10'd0;
                    leds_d[LED_P1]    = p2_e & ~p1_e;
                    leds_d[LED_P2]    = p1_e & ~p2_e;
                    leds_d[LED_TIE]   = p1_e & p2_e;
                    leds_d[LED_FALSE] = 1'b1;
                    state_d           = ST_RESULT;
                end else if (!creset_q && counter >= {6'd0, delay_q}) begin
                    creset_d = 1'b1;
                    state_d  = ST_GO;
                end
            end
            ST_GO: begin
                if (p1_e | p2_e) begin
                    p1_pt           = p1_e & ~p2_e;
                    p2_pt           = p2_e & ~p1_e;
                    num_d           = counter;
                    leds_d          = 10'd0;
                    leds_d[LED_P1]  = p1_e & ~p2_e;
                    leds_d[LED_P2]  = p2_e & ~p1_e;
                    leds_d[LED_TIE] = p1_e & p2_e;
                    state_d         = ST_RESULT;
                end else if (!creset_q && counter >= TIMEOUT_Q) begin
                    num_d           = TIMEOUT_Q;
                    leds_d          = 10'd0;
                    leds_d[LED_TIE] = 1'b1;
                    state_d         = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_e) begin
                    if (p1_score_q == WIN_Q || p2_score_q == WIN_Q) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_ARM;
                        rngr_d  = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (res_e) begin
                    p1_score_d = 4'd0;
                    p2_score_d = 4'd0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (p1_pt) p1_score_d = sat_inc(p1_score_q);
        if (p2_pt) p2_score_d = sat_inc(p2_score_q);

        // Display and lamps follow the state being entered so they register alongside it.
        case (state_d)
            ST_IDLE: begin
                sel_d   = SEL_SCORE;
                pause_d = 1'b1;
                leds_d  = 10'd0;
                num_d   = {12'd0, p1_score_d, p2_score_d};
            end
            ST_ARM: begin
                sel_d   = SEL_BLANK;
                pause_d = 1'b1;
                leds_d  = 10'd0;
            end
            ST_DELAY: begin
                sel_d   = SEL_BLANK;
                pause_d = 1'b0;
                leds_d  = 10'd0;
            end
            ST_GO: begin
                sel_d   = SEL_BLANK;
                pause_d = 1'b0;
                leds_d  = 10'h3FF;
            end
            ST_RESULT: begin
                sel_d   = SEL_TIME;
                pause_d = 1'b1;
            end
            ST_OVER: begin
                sel_d   = SEL_WIN;
                pause_d = 1'b1;
                leds_d  = 10'd0;
                num_d   = (p1_score_d == WIN_Q) ? 20'd1 : 20'd2;
            end
            default: begin
                sel_d   = SEL_SCORE;
                pause_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            p1_score_q <= 4'd0;
            p2_score_q <= 4'd0;
            delay_q    <= 14'd0;
            num_q      <= 20'd0;
            leds_q     <= 10'd0;
            sel_q      <= SEL_SCORE;
            pause_q    <= 1'b1;
            creset_q   <= 1'b1;
            rngr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            delay_q    <= delay_d;
            num_q      <= num_d;
            leds_q     <= leds_d;
            sel_q      <= sel_d;
            pause_q    <= pause_d;
            creset_q   <= creset_d;
            rngr_q     <= rngr_d;
        end
    end

    assign counter_pause = pause_q;
    assign counter_reset = creset_q;
    assign rng_resume    = rngr_q;
    assign MUL_sel       = sel_q;
    assign output_num    = num_q;
    assign LEDs          = leds_q;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb/tb_reaction_round_ctrl.sv - directed rounds against a game-rule model with an emulated ms counter
module tb_reaction_round_ctrl;
    import reaction_pkg::*;

    localparam int WIN = 5;
    localparam int TMO = 2000;
`ifdef FALSE_START_DETECT_EN
    localparam bit FS = 1'b1;
`else
    localparam bit FS = 1'b0;
`endif
    localparam int MS_IDLE = 0, MS_ARM = 1, MS_DELAY = 2, MS_GO = 3, MS_RESULT = 4, MS_OVER = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        resume = 1'b0;
    logic        p1 = 1'b0;
    logic        p2 = 1'b0;
    logic [19:0] counter = 20'd0;
    logic        rnd_ready = 1'b1;
    logic [13:0] rnd_num = 14'd300;
    logic        counter_pause, counter_reset, rng_resume;
    logic [1:0]  MUL_sel;
    logic [19:0] output_num;
    logic [9:0]  LEDs;

    int n_pass = 0;
    int n_total = 0;

    reaction_round_ctrl #(.WIN_SCORE(WIN), .TIMEOUT_MS(TMO)) dut (
        .clock(clock), .reset(reset), .resume(resume), .p1(p1), .p2(p2),
        .counter(counter), .rnd_ready(rnd_ready), .rnd_num(rnd_num),
        .counter_pause(counter_pause), .counter_reset(counter_reset),
        .rng_resume(rng_resume), .MUL_sel(MUL_sel), .output_num(output_num), .LEDs(LEDs)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // External millisecond counter: one tick per clock unless frozen, cleared by the pulse.
    always @(posedge clock) begin
        counter <= counter_reset ? 20'd0 : (counter_pause ? counter : counter + 20'd1);
    end

    // Game-rule model
    int  m_state = MS_IDLE;
    int  m_s1 = 0, m_s2 = 0, m_delay = 0, m_num = 0;
    logic [9:0] m_leds = 10'd0;
    bit  m_creset = 1'b1, m_rngr = 1'b0, m_valid = 1'b0, m_in_rst = 1'b1;
    bit  m_pv1 = 1'b1, m_pv2 = 1'b1, m_pvr = 1'b1;
    bit  e1, e2, er, clr;

    task automatic award(input bit pt1, input bit pt2, input bit tie, input bit fs, input int num);
        m_leds  = {pt1, pt2, tie, fs, 6'd0};
        m_num   = num;
        if (pt1 && m_s1 < 15) m_s1 = m_s1 + 1;
        if (pt2 && m_s2 < 15) m_s2 = m_s2 + 1;
        m_state = MS_RESULT;
    endtask

    always @(posedge clock) begin
        m_in_rst = reset;
        if (reset) begin
            m_valid = 1'b1; m_state = MS_IDLE; m_s1 = 0; m_s2 = 0; m_num = 0;
            m_leds = 10'd0; m_creset = 1'b1; m_rngr = 1'b0;
            m_pv1 = 1'b1; m_pv2 = 1'b1; m_pvr = 1'b1;
        end else begin
            e1 = p1 && !m_pv1;
            e2 = p2 && !m_pv2;
            er = resume && !m_pvr;
            clr = m_creset;
            m_creset = 1'b0;
            m_rngr = 1'b0;
            case (m_state)
                MS_IDLE: if (er) begin m_state = MS_ARM; m_rngr = 1'b1; end
                MS_ARM: if (rnd_ready) begin m_delay = int'(rnd_num); m_creset = 1'b1; m_state = MS_DELAY; end
                MS_DELAY: begin
                    if (FS && (e1 || e2)) award(e2 && !e1, e1 && !e2, e1 && e2, 1'b1, 0);
                    else if (!clr && int'(counter) >= m_delay) begin m_state = MS_GO; m_creset = 1'b1; end
                end
                MS_GO: begin
                    if (e1 || e2) award(e1 && !e2, e2 && !e1, e1 && e2, 1'b0, int'(counter));
                    else if (!clr && int'(counter) >= TMO) award(1'b0, 1'b0, 1'b1, 1'b0, TMO);
                end
                MS_RESULT: if (er) begin
                    if (m_s1 == WIN || m_s2 == WIN) m_state = MS_OVER;
                    else begin m_state = MS_ARM; m_rngr = 1'b1; end
                end
                MS_OVER: if (er) begin m_s1 = 0; m_s2 = 0; m_state = MS_IDLE; end
                default: m_state = MS_IDLE;
            endcase
            if (m_state == MS_IDLE) m_num = m_s1 * 16 + m_s2;
            else if (m_state == MS_OVER) m_num = (m_s1 == WIN) ? 1 : 2;
            m_pv1 = p1; m_pv2 = p2; m_pvr = resume;
        end
    end

    function automatic logic [1:0] exp_sel(input int st);
        case (st)
            MS_IDLE:   return SEL_SCORE;
            MS_RESULT: return SEL_TIME;
            MS_OVER:   return SEL_WIN;
            default:   return SEL_BLANK;
        endcase
    endfunction

    bit cr_prev = 1'b0, rr_prev = 1'b0, rst_prev = 1'b1;
    logic [9:0]  e_leds;
    logic [34:0] e_vec;

    always @(negedge clock) begin
        if (m_valid) begin
            e_leds = (m_state == MS_GO) ? 10'h3FF : (m_state == MS_RESULT) ? m_leds : 10'd0;
            e_vec  = {exp_sel(m_state), (m_state != MS_DELAY && m_state != MS_GO),
                      m_creset, m_rngr, 20'(m_num), e_leds};
            check("outputs", {MUL_sel, counter_pause, counter_reset, rng_resume, output_num, LEDs}, e_vec);
            if (!rst_prev) begin
                if (counter_reset) check("creset_single", cr_prev, 0);
                if (rng_resume)    check("rng_single", rr_prev, 0);
            end
            cr_prev  = counter_reset;
            rr_prev  = rng_resume;
            rst_prev = m_in_rst;
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_resume();
        resume = 1'b1; tick();
        resume = 1'b0; tick();
    endtask

    function automatic bit cond(input int what, input int val);
        case (what)
            0:       return LEDs == 10'h3FF;
            1:       return MUL_sel == SEL_TIME;
            2:       return int'(counter) == val;
            default: return counter_pause == 1'b0 && LEDs == 10'd0;
        endcase
    endfunction

    task automatic wait_until(input int what, input int val, input string name);
        int n = 0;
        while (!cond(what, val) && n < 5000) begin
            tick();
            n++;
        end
        check(name, cond(what, val), 1);
    endtask

    task automatic press_p1_at(input int cnt);
        wait_until(0, 0, "reach_go");
        wait_until(2, cnt, "reach_count");
        p1 = 1'b1; tick(); p1 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"},    MUL_sel, SEL_SCORE);
        check({tag, "_pause"},  counter_pause, 1);
        check({tag, "_creset"}, counter_reset, 1);
        check({tag, "_rng"},    rng_resume, 0);
        check({tag, "_num"},    output_num, 0);
        check({tag, "_leds"},   LEDs, 0);
    endtask

    initial begin
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Round 1: p1 reacts at 150 ms
        pulse_resume();
        press_p1_at(150);
        check("r1_num", output_num, 150);
        check("r1_leds", LEDs, 10'h200);
        check("r1_sel", MUL_sel, SEL_TIME);
        check("r1_score", dut.p1_score_q, 1);
        check("model_r1_num", m_num, 150);

        // Round 2: tie
        rnd_num = 14'd20;
        pulse_resume();
        wait_until(0, 0, "r2_go");
        wait_until(2, 40, "r2_cnt");
        p1 = 1'b1; p2 = 1'b1; tick(); p1 = 1'b0; p2 = 1'b0;
        check("r2_leds", LEDs, 10'h080);
        check("r2_sel", MUL_sel, SEL_TIME);
        check("r2_s1", dut.p1_score_q, 1);
        check("r2_s2", dut.p2_score_q, 0);

        // Round 3: nobody presses
        pulse_resume();
        wait_until(0, 0, "r3_go");
        wait_until(1, 0, "r3_result");
        check("r3_num", output_num, 2000);
        check("r3_leds", LEDs, 10'h080);

        // Round 4: p2 presses during the random delay
        pulse_resume();
        wait_until(3, 0, "r4_delay");
        tick(); tick();
        p2 = 1'b1; tick(); p2 = 1'b0;
`ifdef FALSE_START_DETECT_EN
        check("r4_leds", LEDs, 10'h240);
        check("r4_num", output_num, 0);
        check("r4_s1", dut.p1_score_q, 2);
`else
        check("r4_still_delay_leds", LEDs, 0);
        check("r4_still_delay_pause", counter_pause, 0);
        check("r4_still_delay_sel", MUL_sel, SEL_BLANK);
        press_p1_at(10);
        check("r4_leds", LEDs, 10'h200);
        check("r4_s1", dut.p1_score_q, 2);
`endif

        // Rounds 5-7: p1 reaches the winning score
        for (int i = 0; i < 3; i++) begin
            pulse_resume();
            press_p1_at(5 + i);
            check("win_round_leds", LEDs, 10'h200);
            check("win_round_num", output_num, 5 + i);
        end
        check("model_s1_win", m_s1, 5);
        pulse_resume();
        check("over_sel", MUL_sel, SEL_WIN);
        check("over_num", output_num, 1);
        check("over_pause", counter_pause, 1);
        pulse_resume();
        check("idle_num", output_num, 0);
        check("idle_sel", MUL_sel, SEL_SCORE);

        // Reset mid-GO with p1 held; the held button must not score afterwards
        p1 = 1'b1; tick();
        pulse_resume();
        wait_until(0, 0, "r8_go");
        repeat (5) tick();
        reset = 1'b1; tick(); tick();
        check_reset_outputs("midgo_rst");
        reset = 1'b0; tick();
        pulse_resume();
        wait_until(0, 0, "r9_go");
        wait_until(1, 0, "r9_result");
        check("r9_leds", LEDs, 10'h080);
        check("r9_num", output_num, 2000);
        check("r9_s1", dut.p1_score_q, 0);
        p1 = 1'b0; tick();
        pulse_resume();
        press_p1_at(30);
        check("r10_leds", LEDs, 10'h200);
        check("r10_num", output_num, 30);
        check("r10_s1", dut.p1_score_q, 1);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
